// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read arbiter.
// Optional watchdog feature is enabled in the top with AXI_RD_ARB_TIMEOUT_EN.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         BEAT_W         = 512;
    localparam int         IDX_W          = 3;

    // Clear the byte offset inside one 64-byte beat.
    function automatic logic [63:0] beat_align(input logic [63:0] addr);
        return addr & ~64'h3F;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// ptr_i, wrapping from NUM_REQ-1 back to 0. Emits one-hot grant and index.
module rr_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_rot;

    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl >> ptr_i;

    // Scan the rotated vector from the top down so the lowest offset wins last.
    always_comb begin
        logic [IDX_W:0] sum;
        sum   = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                end
                idx_o = sum[IDX_W-1:0];
                any_o = 1'b1;
            end
        end
    end

    // Decode the winning index into a one-hot grant.
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = any_o && (idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin sharing of one 512-bit AXI read master among NUM_REQ clients.
// One INCR burst in flight at a time; R beats are steered to the granted client.
// Define AXI_RD_ARB_TIMEOUT_EN to add a per-burst watchdog (TIMEOUT_CYCLES).
module axi_read_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  axis_clk,
    input  logic                  axis_rstn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]  req_len,
    output logic [BEAT_W-1:0]     cl_rdata,
    output logic [1:0]            cl_rresp,
    output logic                  cl_rlast,
    output logic [NUM_REQ-1:0]    cl_rvalid,
    input  logic [NUM_REQ-1:0]    cl_rready,
    output logic [3:0]            m_axi_arid,
    output logic [63:0]           m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [3:0]            m_axi_rid,
    input  logic [BEAT_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  busy,
    output logic [2:0]            grant_idx,
    output logic                  rid_err,
    output logic                  timeout_err
);

    arb_state_e         state_q, state_d;
    logic               arvalid_q, arvalid_d;
    logic [63:0]        araddr_q, araddr_d;
    logic [7:0]         arlen_q, arlen_d;
    logic [3:0]         arid_q, arid_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               rid_err_q, rid_err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [63:0]        win_addr;
    logic [7:0]         win_len;
    logic               sel_rready;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        logic [IDX_W:0] s;
        s = {1'b0, g} + 1'b1;
        if (s >= (IDX_W+1)'(NUM_REQ)) begin
            s = '0;
        end
        return s[IDX_W-1:0];
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Pick the winner's address and length out of the packed request buses.
    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_addr = req_addr[i*64 +: 64];
                win_len  = req_len[i*8 +: 8];
            end
        end
    end

    // Ready of the currently granted client, used as the master rready.
    always_comb begin
        sel_rready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_rready = cl_rready[i];
            end
        end
    end

`ifdef AXI_RD_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        to_err_q, to_err_d;
`endif

    // Next-state logic for the grant/address/data sequence and beat steering.
    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arid_d       = arid_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        rid_err_d    = rid_err_q;
        req_ready    = '0;
        cl_rvalid    = '0;
        m_axi_rready = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    araddr_d  = beat_align(win_addr);
                    arlen_d   = win_len;
                    arid_d    = {1'b0, arb_idx};
                    grant_d   = arb_idx;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                m_axi_rready = sel_rready;
                for (int i = 0; i < NUM_REQ; i++) begin
                    cl_rvalid[i] = m_axi_rvalid && (grant_q == IDX_W'(i));
                end
                if (m_axi_rvalid && sel_rready) begin
                    // A mismatched rid is flagged but the beat is still delivered.
                    if (m_axi_rid != arid_q) begin
                        rid_err_d = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr(grant_q);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
            end
        endcase

`ifdef AXI_RD_ARB_TIMEOUT_EN
        to_err_d = to_err_q;
        wd_cnt_d = (state_q == IDLE) ? 32'd0 : wd_cnt_q + 32'd1;
        // A burst that never completes is abandoned so other clients keep moving.
        if (state_q != IDLE && state_d != IDLE &&
            wd_cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
            to_err_d  = 1'b1;
            arvalid_d = 1'b0;
            state_d   = IDLE;
            ptr_d     = next_ptr(grant_q);
        end
`endif
    end

    // State and AR-channel registers.
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            rid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            rid_err_q <= rid_err_d;
        end
    end

`ifdef AXI_RD_ARB_TIMEOUT_EN
    // Watchdog counter and its sticky error flag.
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            wd_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err = to_err_q;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_err = 1'b0;
`endif

    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = AXI_SIZE_64B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = arvalid_q;

    assign cl_rdata  = m_axi_rdata;
    assign cl_rresp  = m_axi_rresp;
    assign cl_rlast  = m_axi_rlast;

    assign busy      = (state_q != IDLE);
    assign grant_idx = grant_q;
    assign rid_err   = rid_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed + randomized bench for axi_read_arbiter with a slave driven inline
// and a round-robin reference model. Watchdog scenario runs only when
// AXI_RD_ARB_TIMEOUT_EN is defined.
module tb_axi_read_arbiter;

    localparam int N = 4;
`ifdef AXI_RD_ARB_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*64-1:0] req_addr = '0;
    logic [N*8-1:0] req_len = '0;
    logic [511:0]   cl_rdata;
    logic [1:0]     cl_rresp;
    logic           cl_rlast;
    logic [N-1:0]   cl_rvalid;
    logic [N-1:0]   cl_rready = '1;
    logic [3:0]     arid;
    logic [63:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arlock;
    logic [3:0]     arcache;
    logic [2:0]     arprot;
    logic           arvalid;
    logic           arready = 1'b0;
    logic [3:0]     rid = '0;
    logic [511:0]   rdata = '0;
    logic [1:0]     rresp = '0;
    logic           rlast = 1'b0;
    logic           rvalid = 1'b0;
    logic           rready;
    logic           busy;
    logic [2:0]     grant_idx;
    logic           rid_err;
    logic           timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ptr = 0;
    logic        m_rid_err = 1'b0;
    logic [63:0] c_addr [N];
    logic [7:0]  c_len  [N];

    always #5 clk = ~clk;

    axi_read_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .axis_clk      (clk),
        .axis_rstn     (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .cl_rdata      (cl_rdata),
        .cl_rresp      (cl_rresp),
        .cl_rlast      (cl_rlast),
        .cl_rvalid     (cl_rvalid),
        .cl_rready     (cl_rready),
        .m_axi_arid    (arid),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_arlock  (arlock),
        .m_axi_arcache (arcache),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rid     (rid),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .busy          (busy),
        .grant_idx     (grant_idx),
        .rid_err       (rid_err),
        .timeout_err   (timeout_err)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_winner(input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            int c;
            c = (m_ptr + off) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic load_clients();
        for (int i = 0; i < N; i++) begin
            req_addr[i*64 +: 64] = c_addr[i];
            req_len[i*8 +: 8]    = c_len[i];
        end
    endtask

    // One full burst: request, AR handshake after ar_wait stalls, R beats.
    // rid_force < 0 means the slave echoes the correct id.
    task automatic run_burst(input logic [N-1:0] vld, input int ar_wait,
                             input int rid_force, input bit toggle_rdy,
                             input bit keep_valid);
        int           w;
        int           got;
        int           cyc;
        logic [N-1:0] oh;
        logic [63:0]  exp_addr;
        logic [7:0]   len;
        w        = model_winner(vld);
        oh       = '0;
        oh[w]    = 1'b1;
        exp_addr = c_addr[w] & ~64'h3F;
        len      = c_len[w];
        load_clients();
        req_valid = vld;
        @(negedge clk);
        chk("req_ready_pulse", req_ready, oh);
        chk("busy_idle", busy, 1'b0);
        tick();
        if (!keep_valid) req_valid = '0;
        @(negedge clk);
        chk("arvalid", arvalid, 1'b1);
        chk("araddr", araddr, exp_addr);
        chk("arlen", arlen, len);
        chk("arid", arid, 4'(w));
        chk("grant_idx", grant_idx, 3'(w));
        chk("busy_addr", busy, 1'b1);
        chk("req_ready_busy", req_ready, '0);
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            @(negedge clk);
            chk("arvalid_hold", arvalid, 1'b1);
            chk("araddr_hold", araddr, exp_addr);
        end
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        got = 0;
        cyc = 0;
        while (got <= int'(len) && cyc < 300) begin
            rvalid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 16; k++) rdata[k*32 +: 32] = $urandom;
            rresp = 2'($urandom_range(0, 3));
            rlast = (got == int'(len));
            rid   = (rid_force < 0) ? 4'(w) : 4'(rid_force);
            cl_rready = toggle_rdy ? N'($urandom) : '1;
            @(negedge clk);
            chk("rready_mirror", rready, cl_rready[w]);
            chk("cl_rvalid", cl_rvalid, rvalid ? oh : '0);
            if (rvalid) begin
                chk("cl_rdata", cl_rdata, rdata);
                chk("cl_rlast", cl_rlast, rlast);
                chk("cl_rresp", cl_rresp, rresp);
            end
            if (rvalid && cl_rready[w]) begin
                got++;
                if (rid != 4'(w)) m_rid_err = 1'b1;
            end
            cyc++;
            tick();
        end
        rvalid    = 1'b0;
        rlast     = 1'b0;
        cl_rready = '1;
        m_ptr     = (w + 1) % N;
        chk("beat_count", got, int'(len) + 1);
        chk("busy_done", busy, 1'b0);
        chk("rid_err", rid_err, m_rid_err);
    endtask

    initial begin
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = 64'h0;
            c_len[i]  = 8'd0;
        end

        // Reset state
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_cl_rvalid", cl_rvalid, '0);
        chk("rst_araddr", araddr, 64'h0);
        chk("rst_arlen", arlen, 8'h0);
        chk("rst_arid", arid, 4'h0);
        chk("rst_grant", grant_idx, 3'h0);
        chk("rst_rid_err", rid_err, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("arsize", arsize, 3'b110);
        chk("arburst", arburst, 2'b01);
        chk("arlock_cache_prot", {arlock, arcache, arprot}, 8'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // All four clients valid, single-beat bursts: 0,1,2,3,0
        for (int i = 0; i < N; i++) begin
            c_addr[i] = 64'h100 * (i + 1);
            c_len[i]  = 8'd0;
        end
        for (int g = 0; g < 5; g++) begin
            chk("rr_order", 32'(model_winner(4'b1111)), 32'(g % N));
            run_burst(4'b1111, 0, -1, 1'b0, 1'b1);
        end
        req_valid = '0;
        tick();

        // Client 0 only, 4-beat burst
        c_addr[0] = 64'h1040;
        c_len[0]  = 8'd3;
        run_burst(4'b0001, 0, -1, 1'b0, 1'b0);

        // Unaligned address, AR stalled for 10 cycles
        c_addr[2] = 64'h2007;
        c_len[2]  = 8'd1;
        run_burst(4'b0100, 10, -1, 1'b0, 1'b0);

        // Toggling client ready over an 8-beat burst
        c_addr[1] = 64'h3000;
        c_len[1]  = 8'd7;
        run_burst(4'b0010, 1, -1, 1'b1, 1'b0);

        // Idle with no requests: nothing starts
        tick();
        tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_arvalid", arvalid, 1'b0);

        // Wrong rid from slave: sticky flag, data delivered
        c_len[1] = 8'd2;
        run_burst(4'b0010, 0, 5, 1'b0, 1'b0);
        chk("rid_err_sticky", rid_err, 1'b1);
        c_len[3] = 8'd0;
        run_burst(4'b1000, 0, -1, 1'b0, 1'b0);
        chk("rid_err_still", rid_err, 1'b1);

        // Randomized bursts
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                c_addr[i] = {$urandom, $urandom};
                c_len[i]  = 8'($urandom_range(0, 7));
            end
            v = N'($urandom_range(1, (1 << N) - 1));
            run_burst(v, $urandom_range(0, 3), -1, 1'($urandom), 1'($urandom));
            req_valid = '0;
        end

        // Async reset in the middle of a data phase
        load_clients();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        arready   = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rid     = 4'd3;
        tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_arvalid", arvalid, 1'b0);
        chk("mid_rst_rready", rready, 1'b0);
        chk("mid_rst_cl_rvalid", cl_rvalid, '0);
        chk("mid_rst_rid_err", rid_err, 1'b0);
        chk("mid_rst_grant", grant_idx, 3'h0);
        rvalid = 1'b0;
        @(negedge clk);
        rstn      = 1'b1;
        m_ptr     = 0;
        m_rid_err = 1'b0;
        tick();
        c_len[2] = 8'd1;
        run_burst(4'b0110, 0, -1, 1'b0, 1'b0);

`ifdef AXI_RD_ARB_TIMEOUT_EN
        // Slave never answers AR: watchdog abandons the burst
        begin
            int n;
            load_clients();
            req_valid = 4'b0001;
            tick();
            req_valid = '0;
            n = 0;
            while (busy && n < 300) begin
                tick();
                n++;
            end
            chk("timeout_cycles", n, TO);
            chk("timeout_err", timeout_err, 1'b1);
            chk("timeout_arvalid", arvalid, 1'b0);
            m_ptr = 1;
            c_len[1] = 8'd0;
            run_burst(4'b1111, 0, -1, 1'b0, 1'b0);
        end
`else
        chk("timeout_err_tied", timeout_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
